mdio_master: RTL and testbench

Parametrised IEEE 802.3 Clause 22 MDIO management master: accepts one read or write command at a time over a valid/ready handshake and serialises it onto MDC/MDIO. It drives the PHY configuration interface and generalises the fixed-address, write-only sequencer to any PHY or register address, real read-back, a programmable MDC divider and a programmable preamble length. The pad-side tri-state is split into `mdio_o`, `mdio_oe` and `mdio_i`; the top level combines them into the `mdio` inout.

---
 rtl/mdio_master_if.sv | 25 ++
 rtl/mdio_master.sv | 148 ++++++++++++++
 tb/tb_mdio_master.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_master_if.sv
// Command/response bundle for mdio_master: one command in flight, a single-cycle
// completion pulse and the last read-back word.
interface mdio_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [4:0]  cmd_phy;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;

  // Requester side (the logic issuing management commands).
  modport master (
    output cmd_valid, cmd_read, cmd_phy, cmd_reg, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  // Serialiser side.
  modport slave (
    input  cmd_valid, cmd_read, cmd_phy, cmd_reg, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/mdio_master.sv
// Clause 22 MDIO master: serialises one read/write frame at a time onto MDC/MDIO,
// with programmable MDC half-period and preamble length.
module mdio_master #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  mdio_master_if.slave bus,
  output logic         mdc,
  output logic         mdio_o,
  output logic         mdio_oe,
  input  logic         mdio_i
);

  localparam int unsigned     DivW    = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [4:0]      PreLast = (PREAMBLE_LEN == 0) ? 5'd0 : 5'(PREAMBLE_LEN - 1);

  typedef enum logic [2:0] {
    StIdle, StPre, StSt, StOp, StPhyad, StRegad, StTa, StData
  } state_e;

  state_e          state_q;
  logic [4:0]      bit_q;
  logic [DivW-1:0] div_q;
  logic            mdc_q;
  logic            mdio_o_q;
  logic            mdio_oe_q;
  logic            rsp_valid_q;
  logic [15:0]     rsp_rdata_q;
  logic [15:0]     shift_q;
  logic            read_q;
  logic [4:0]      phy_q;
  logic [4:0]      reg_q;
  logic [15:0]     wdata_q;

  state_e     nxt_state;
  logic [4:0] nxt_bit;
  logic [4:0] last_bit;
  logic       nxt_o;
  logic       nxt_oe;

  // Field position after the current bit and the value/enable to present for it.
  always_comb begin
    case (state_q)
      StPre:            last_bit = PreLast;
      StPhyad, StRegad: last_bit = 5'd4;
      StData:           last_bit = 5'd15;
      default:          last_bit = 5'd1;
    endcase

    nxt_state = state_q;
    nxt_bit   = bit_q + 5'd1;
    if (bit_q == last_bit) begin
      nxt_bit = '0;
      case (state_q)
        StPre:   nxt_state = StSt;
        StSt:    nxt_state = StOp;
        StOp:    nxt_state = StPhyad;
        StPhyad: nxt_state = StRegad;
        StRegad: nxt_state = StTa;
        StTa:    nxt_state = StData;
        default: nxt_state = StIdle;
      endcase
    end

    // Reads release the line from turnaround onwards; a released line reads as 1.
    nxt_oe = !(read_q && (nxt_state == StTa || nxt_state == StData));
    case (nxt_state)
      StSt:    nxt_o = nxt_bit[0];
      StOp:    nxt_o = read_q ? ~nxt_bit[0] : nxt_bit[0];
      StPhyad: nxt_o = phy_q[3'd4 - nxt_bit[2:0]];
      StRegad: nxt_o = reg_q[3'd4 - nxt_bit[2:0]];
      StTa:    nxt_o = read_q | ~nxt_bit[0];
      StData:  nxt_o = read_q | wdata_q[4'd15 - nxt_bit[3:0]];
      default: nxt_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_q       <= '0;
      div_q       <= '0;
      mdc_q       <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      shift_q     <= '0;
      read_q      <= 1'b0;
      phy_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q == StIdle) begin
        if (bus.cmd_valid) begin
          read_q    <= bus.cmd_read;
          phy_q     <= bus.cmd_phy;
          reg_q     <= bus.cmd_reg;
          wdata_q   <= bus.cmd_wdata;
          state_q   <= (PREAMBLE_LEN == 0) ? StSt : StPre;
          bit_q     <= '0;
          div_q     <= '0;
          mdc_q     <= 1'b0;
          mdio_o_q  <= (PREAMBLE_LEN != 0);
          mdio_oe_q <= 1'b1;
        end
      end else if (div_q != DivLast) begin
        div_q <= div_q + 1'b1;
      end else begin
        div_q <= '0;
        mdc_q <= ~mdc_q;
        if (!mdc_q) begin
          // Rising MDC edge: the PHY's data bit is sampled here.
          if (state_q == StData) begin
            shift_q <= {shift_q[14:0], mdio_i};
          end
        end else begin
          state_q <= nxt_state;
          bit_q   <= nxt_bit;
          if (nxt_state == StIdle) begin
            rsp_valid_q <= 1'b1;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
            if (read_q) begin
              rsp_rdata_q <= shift_q;
            end
          end else begin
            mdio_o_q  <= nxt_o;
            mdio_oe_q <= nxt_oe;
          end
        end
      end
    end
  end

  assign bus.cmd_ready = (state_q == StIdle) && !rst;
  assign bus.busy      = (state_q != StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign mdc           = mdc_q;
  assign mdio_o        = mdio_o_q;
  assign mdio_oe       = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: two instances (CLK_DIV=2/PRE=32 and CLK_DIV=3/PRE=0), a frame
// model built from the field layout, a PHY responder and cycle-level timing checks.
module tb_mdio_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        mdio_i;
  logic        c_valid, c_read;
  logic [4:0]  c_phy, c_reg;
  logic [15:0] c_wdata;
  logic        mdc0, mo0, moe0, mdc1, mo1, moe1;

  mdio_master_if bus0 ();
  mdio_master_if bus1 ();

  assign bus0.cmd_valid = c_valid & ~sel;
  assign bus0.cmd_read  = c_read;
  assign bus0.cmd_phy   = c_phy;
  assign bus0.cmd_reg   = c_reg;
  assign bus0.cmd_wdata = c_wdata;
  assign bus1.cmd_valid = c_valid & sel;
  assign bus1.cmd_read  = c_read;
  assign bus1.cmd_phy   = c_phy;
  assign bus1.cmd_reg   = c_reg;
  assign bus1.cmd_wdata = c_wdata;

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .mdc(mdc0), .mdio_o(mo0), .mdio_oe(moe0), .mdio_i(mdio_i)
  );
  mdio_master #(.CLK_DIV(3), .PREAMBLE_LEN(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .mdc(mdc1), .mdio_o(mo1), .mdio_oe(moe1), .mdio_i(mdio_i)
  );

  logic        p_mdc, p_mo, p_moe, p_ready, p_rsp, p_busy;
  logic [15:0] p_rdata;
  assign p_mdc   = sel ? mdc1 : mdc0;
  assign p_mo    = sel ? mo1 : mo0;
  assign p_moe   = sel ? moe1 : moe0;
  assign p_ready = sel ? bus1.cmd_ready : bus0.cmd_ready;
  assign p_rsp   = sel ? bus1.rsp_valid : bus0.rsp_valid;
  assign p_busy  = sel ? bus1.busy : bus0.busy;
  assign p_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        exp_o [64];
  logic        exp_oe[64];
  logic        obs_o [64];
  logic        obs_oe[64];
  logic [15:0] last_rdata[2];

  typedef struct {
    logic        rd;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    logic [15:0] pd;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s %s: got 0x%0h, want 0x%0h", tag, what, act, exp);
    end
  endtask

  function automatic int cur_d();
    return sel ? 3 : 2;
  endfunction

  function automatic int cur_p();
    return sel ? 0 : 32;
  endfunction

  // Expected per-bit line value and enable for a whole frame; returns the bit count.
  function automatic int build_frame(input logic rd, input logic [4:0] phy, input logic [4:0] rg,
                                     input logic [15:0] wd, input int p);
    logic [31:0] body;
    int          j;
    body = {2'b01, rd ? 2'b10 : 2'b01, phy, rg, rd ? 2'b11 : 2'b10, rd ? 16'hFFFF : wd};
    for (int i = 0; i < p + 32; i++) begin
      if (i < p) begin
        exp_o[i]  = 1'b1;
        exp_oe[i] = 1'b1;
      end else begin
        j         = i - p;
        exp_o[i]  = body[31-j];
        exp_oe[i] = !(rd && j >= 14);
      end
    end
    return p + 32;
  endfunction

  task automatic issue(input logic rd, input logic [4:0] phy, input logic [4:0] rg,
                       input logic [15:0] wd);
    int w;
    @(negedge clk);
    c_read  = rd;
    c_phy   = phy;
    c_reg   = rg;
    c_wdata = wd;
    c_valid = 1'b1;
    w = 0;
    while (!p_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("issue", "ready", p_ready, 1);
    @(posedge clk);
  endtask

  // Follows one accepted frame from cycle T+1 until its response (or abort).
  task automatic monitor(input string tag, input logic rd, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [15:0] wd, input logic [15:0] pd,
                         input logic [15:0] exp_rd, input logic keep, input logic nrd,
                         input logic [4:0] nphy, input logic [4:0] nrg, input logic [15:0] nwd,
                         input int poke_c, input int abort_bit);
    int          n, d, p, nb, run, lat, bad_o, bad_oe, j;
    logic        prev_mdc, prev_o, prev_oe;
    logic        r_mdc, r_moe, r_busy, r_ready;
    logic [15:0] r_rdata;
    bit          timing_ok, stable_ok;
    d = cur_d();
    p = cur_p();
    n = build_frame(rd, phy, rg, wd, p);
    nb = 0; run = 0; lat = -1;
    prev_mdc = 1'b0; prev_o = 1'b1; prev_oe = 1'b0;
    r_mdc = 1'bx; r_moe = 1'bx; r_busy = 1'bx; r_ready = 1'bx; r_rdata = 'x;
    timing_ok = 1'b1; stable_ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      obs_o[i]  = 1'bx;
      obs_oe[i] = 1'bx;
    end
    for (int c = 1; c <= n * 2 * d + 16 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check(tag, "busy_at_start", p_busy, 1);
        if (keep) begin
          c_read = nrd; c_phy = nphy; c_reg = nrg; c_wdata = nwd;
        end else begin
          c_valid = 1'b0;
        end
      end
      if (c == poke_c) begin
        check(tag, "ready_while_busy", p_ready, 0);
        c_read = ~rd; c_phy = ~phy; c_wdata = ~wd; c_valid = 1'b1;
      end
      if (c == poke_c + 1) c_valid = 1'b0;
      if (c > 1 && !(prev_mdc && !p_mdc) && (p_mo !== prev_o || p_moe !== prev_oe))
        stable_ok = 1'b0;
      if (p_mdc !== prev_mdc) begin
        if (run != d) timing_ok = 1'b0;
        run = 0;
        if (p_mdc) begin
          if (nb < 64) begin
            obs_o[nb]  = p_mo;
            obs_oe[nb] = p_moe;
          end
          nb++;
        end
      end
      run++;
      prev_mdc = p_mdc; prev_o = p_mo; prev_oe = p_moe;
      if (!p_mdc) begin
        j = nb - p - 16;
        mdio_i = (rd && j >= 0 && j < 16) ? pd[15-j] : 1'b1;
      end
      if (abort_bit >= 0 && nb == abort_bit && !p_mdc) begin
        rst = 1'b1;
        @(negedge clk);
        check(tag, "abort_mdc", p_mdc, 0);
        check(tag, "abort_mdio_o", p_mo, 1);
        check(tag, "abort_oe", p_moe, 0);
        check(tag, "abort_busy", p_busy, 0);
        check(tag, "abort_rsp", p_rsp, 0);
        check(tag, "abort_ready", p_ready, 0);
        rst = 1'b0;
        mdio_i = 1'b1;
        last_rdata[sel] = '0;
        return;
      end
      if (p_rsp) begin
        lat = c;
        r_mdc = p_mdc; r_moe = p_moe; r_busy = p_busy; r_ready = p_ready; r_rdata = p_rdata;
      end
    end
    bad_o = 0;
    bad_oe = 0;
    for (int i = 0; i < n; i++) begin
      if (obs_o[i] !== exp_o[i]) bad_o++;
      if (obs_oe[i] !== exp_oe[i]) bad_oe++;
    end
    check(tag, "latency", lat, 1 + n * 2 * d);
    check(tag, "bit_count", nb, n);
    check(tag, "stream_bad_bits", bad_o, 0);
    check(tag, "oe_bad_bits", bad_oe, 0);
    check(tag, "rsp_rdata", r_rdata, exp_rd);
    check(tag, "rsp_mdc", r_mdc, 0);
    check(tag, "rsp_oe", r_moe, 0);
    check(tag, "rsp_busy", r_busy, 0);
    check(tag, "rsp_ready", r_ready, 1);
    check(tag, "mdc_phase_len", timing_ok, 1);
    check(tag, "drive_only_low_start", stable_ok, 1);
    last_rdata[sel] = exp_rd;
  endtask

  task automatic frame(input string tag, input logic rd, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [15:0] wd, input logic [15:0] pd,
                       input logic [15:0] exp_rd);
    issue(rd, phy, rg, wd);
    monitor(tag, rd, phy, rg, wd, pd, exp_rd, 1'b0, 1'b0, '0, '0, '0, -1, -1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (p_rsp || p_busy) bad++;
    end
    check(tag, "quiet_after", bad, 0);
  endtask

  task automatic random_frames(input string tag, input int count);
    logic        rd;
    logic [4:0]  phy, rg;
    logic [15:0] wd, pd, exp_rd;
    for (int i = 0; i < count; i++) begin
      rd  = 1'($urandom_range(0, 1));
      phy = 5'($urandom);
      rg  = 5'($urandom);
      wd  = 16'($urandom);
      pd  = 16'($urandom);
      exp_rd = rd ? pd : last_rdata[sel];
      frame(tag, rd, phy, rg, wd, pd, exp_rd);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{rd: 1'b0, phy: 5'h10, rg: 5'h00, wd: 16'hAAAA, pd: 16'h0000, exp_rd: 16'h0000};
    vecs[1] = '{rd: 1'b1, phy: 5'h01, rg: 5'h02, wd: 16'h0000, pd: 16'h1234, exp_rd: 16'h1234};
    vecs[2] = '{rd: 1'b0, phy: 5'h1F, rg: 5'h1F, wd: 16'hFFFF, pd: 16'h0000, exp_rd: 16'h1234};
    vecs[3] = '{rd: 1'b1, phy: 5'h00, rg: 5'h00, wd: 16'h0000, pd: 16'h8001, exp_rd: 16'h8001};
    vecs[4] = '{rd: 1'b1, phy: 5'h15, rg: 5'h0A, wd: 16'hFFFF, pd: 16'h0000, exp_rd: 16'h0000};
    vecs[5] = '{rd: 1'b0, phy: 5'h00, rg: 5'h1E, wd: 16'h0001, pd: 16'hFFFF, exp_rd: 16'h0000};

    rst = 1'b1; sel = 1'b0; mdio_i = 1'b1;
    c_valid = 1'b0; c_read = 1'b0; c_phy = '0; c_reg = '0; c_wdata = '0;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    repeat (3) @(negedge clk);
    check("reset", "ready0", bus0.cmd_ready, 0);
    check("reset", "ready1", bus1.cmd_ready, 0);
    check("reset", "rsp_valid0", bus0.rsp_valid, 0);
    check("reset", "rsp_rdata0", bus0.rsp_rdata, 0);
    check("reset", "busy0", bus0.busy, 0);
    check("reset", "mdc0", mdc0, 0);
    check("reset", "mdio_o0", mo0, 1);
    check("reset", "mdio_oe0", moe0, 0);
    check("reset", "mdio_o1", mo1, 1);
    check("reset", "mdio_oe1", moe1, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset", "ready0_after", bus0.cmd_ready, 1);
    check("reset", "ready1_after", bus1.cmd_ready, 1);

    for (int i = 0; i < 6; i++) begin
      frame($sformatf("vec%0d", i), vecs[i].rd, vecs[i].phy, vecs[i].rg, vecs[i].wd,
            vecs[i].pd, vecs[i].exp_rd);
    end

    issue(1'b0, 5'h05, 5'h03, 16'h5A5A);
    monitor("busy_ignore", 1'b0, 5'h05, 5'h03, 16'h5A5A, 16'h0, last_rdata[0], 1'b0,
            1'b0, '0, '0, '0, 100, -1);
    quiet("busy_ignore", 40);

    issue(1'b0, 5'h02, 5'h04, 16'h1111);
    monitor("b2b_first", 1'b0, 5'h02, 5'h04, 16'h1111, 16'h0, last_rdata[0], 1'b1,
            1'b0, 5'h03, 5'h05, 16'h2222, -1, -1);
    monitor("b2b_second", 1'b0, 5'h03, 5'h05, 16'h2222, 16'h0, last_rdata[0], 1'b0,
            1'b0, '0, '0, '0, -1, -1);
    quiet("b2b", 40);

    issue(1'b1, 5'h01, 5'h02, 16'h0);
    monitor("abort", 1'b1, 5'h01, 5'h02, 16'h0, 16'hBEEF, 16'hBEEF, 1'b0,
            1'b0, '0, '0, '0, -1, 40);
    quiet("abort", 20);
    frame("after_abort", 1'b0, 5'h10, 5'h00, 16'hAAAA, 16'h0, 16'h0000);

    random_frames("rand0", 8);

    sel = 1'b1;
    frame("nopre_write", 1'b0, 5'h10, 5'h00, 16'hAAAA, 16'h0, 16'h0000);
    frame("nopre_read", 1'b1, 5'h01, 5'h02, 16'h0, 16'h1234, 16'h1234);
    random_frames("rand1", 4);
    quiet("nopre", 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
